// File: rtl/delay_line_var_pkg.sv
// rtl/delay_line_var_pkg.sv - shared sizing and clamp helpers for the variable delay line
package delay_line_var_pkg;

  function automatic int dly_width(input int max_delay);
    return $clog2(max_delay + 1);
  endfunction

  // Software may request any encodable delay; anything deeper than the line saturates.
  function automatic int clamp_dly(input int dly, input int max_delay);
    return (dly > max_delay) ? max_delay : dly;
  endfunction

endpackage

// File: rtl/delay_stage.sv
// rtl/delay_stage.sv - one data register plus valid tag of the delay line
module delay_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         flush,
  input  logic [W-1:0] d,
  input  logic         d_vld,
  output logic [W-1:0] q,
  output logic         q_vld
);

  logic [W-1:0] data_q, data_d;
  logic         vld_q, vld_d;

  // Flush only kills the tag; the data path keeps shifting so it stays aligned.
  always_comb begin
    data_d = en ? d : data_q;
    vld_d  = flush ? 1'b0 : (en ? d_vld : vld_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign q     = data_q;
  assign q_vld = vld_q;

endmodule

// File: rtl/delay_line_var.sv
// rtl/delay_line_var.sv - run-time programmable delay line with valid tagging, stall, flush and occupancy
module delay_line_var
  import delay_line_var_pkg::*;
#(
  parameter int W          = 8,
  parameter int MaxDelay   = 8,
  parameter int ResetDelay = 8,
  localparam int DW        = dly_width(MaxDelay)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          EN,
  input  logic          FLUSH,
  input  logic          DLY_LD,
  input  logic [DW-1:0] DLY,
  input  logic          IN_VLD,
  input  logic [W-1:0]  IN,
  output logic          OUT_VLD,
  output logic [W-1:0]  OUT,
  output logic [DW-1:0] LEVEL
);

  logic [W-1:0]  stage_data [MaxDelay];
  logic          stage_vld  [MaxDelay];
  logic          flush_all;
  logic [DW-1:0] dly_q, dly_d;
  logic [DW-1:0] level_q, level_d;
  logic [W-1:0]  out_data;
  logic          out_vld;

  // A delay change invalidates everything in flight, same as an explicit flush.
  assign flush_all = FLUSH | DLY_LD;

  for (genvar i = 0; i < MaxDelay; i++) begin : g_stage
    if (i == 0) begin : g_head
      delay_stage #(.W(W)) u_stage (
        .clk   (CLK),
        .rst_n (RST_N),
        .en    (EN),
        .flush (flush_all),
        .d     (IN),
        .d_vld (IN_VLD),
        .q     (stage_data[i]),
        .q_vld (stage_vld[i])
      );
    end else begin : g_body
      delay_stage #(.W(W)) u_stage (
        .clk   (CLK),
        .rst_n (RST_N),
        .en    (EN),
        .flush (flush_all),
        .d     (stage_data[i-1]),
        .d_vld (stage_vld[i-1]),
        .q     (stage_data[i]),
        .q_vld (stage_vld[i])
      );
    end
  end

  always_comb begin
    out_data = '0;
    out_vld  = 1'b0;
    if (dly_q == '0) begin
      out_data = IN;
      out_vld  = IN_VLD & EN;
    end else begin
      for (int i = 0; i < MaxDelay; i++) begin
        if (dly_q == DW'(i + 1)) begin
          out_data = stage_data[i];
          out_vld  = stage_vld[i];
        end
      end
    end
  end

  always_comb begin
    dly_d   = dly_q;
    level_d = level_q;
    if (DLY_LD) begin
      dly_d = DW'(clamp_dly(int'(DLY), MaxDelay));
    end
    // Window gains the incoming tag and loses the one leaving at the tap.
    if (flush_all) begin
      level_d = '0;
    end else if (EN) begin
      level_d = level_q + DW'(IN_VLD) - DW'(out_vld);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dly_q   <= DW'(ResetDelay);
      level_q <= '0;
    end else begin
      dly_q   <= dly_d;
      level_q <= level_d;
    end
  end

  assign OUT     = out_data;
  assign OUT_VLD = out_vld;
  assign LEVEL   = level_q;

endmodule

// File: tb/tb_delay_line_var.sv
// tb/tb_delay_line_var.sv - directed vector bench for delay_line_var
module tb_delay_line_var;

  localparam int W  = 8;
  localparam int MD = 8;
  localparam int RD = 8;
  localparam int DW = 4;

  logic          CLK;
  logic          RST_N;
  logic          EN;
  logic          FLUSH;
  logic          DLY_LD;
  logic [DW-1:0] DLY;
  logic          IN_VLD;
  logic [W-1:0]  IN;
  logic          OUT_VLD;
  logic [W-1:0]  OUT;
  logic [DW-1:0] LEVEL;

  delay_line_var #(.W(W), .MaxDelay(MD), .ResetDelay(RD)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .EN      (EN),
    .FLUSH   (FLUSH),
    .DLY_LD  (DLY_LD),
    .DLY     (DLY),
    .IN_VLD  (IN_VLD),
    .IN      (IN),
    .OUT_VLD (OUT_VLD),
    .OUT     (OUT),
    .LEVEL   (LEVEL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string         tag;
    logic          en;
    logic          flush;
    logic          ld;
    logic [DW-1:0] dly;
    logic          vld;
    logic [W-1:0]  din;
    logic          exp_vld;
    logic [W-1:0]  exp_out;
    logic [DW-1:0] exp_lvl;
    logic          chk_out;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic add(input string tag, input logic en, input logic flush, input logic ld,
                     input int dly, input logic vld, input int din, input logic ev,
                     input int eo, input int el, input logic co);
    vec_t v;
    v.tag = tag; v.en = en; v.flush = flush; v.ld = ld; v.dly = DW'(dly);
    v.vld = vld; v.din = W'(din); v.exp_vld = ev; v.exp_out = W'(eo);
    v.exp_lvl = DW'(el); v.chk_out = co;
    vq.push_back(v);
  endtask

  task automatic check(input string tag, input logic ev, input logic [W-1:0] eo,
                       input logic [DW-1:0] el, input logic co);
    n_vec++;
    if (OUT_VLD !== ev || LEVEL !== el || (co && OUT !== eo)) begin
      n_bad++;
      $display("FAIL %s: got out_vld=%0b out=%02h level=%0d, want out_vld=%0b out=%02h level=%0d%s",
               tag, OUT_VLD, OUT, LEVEL, ev, eo, el, co ? "" : " (out not checked)");
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge CLK);
    EN = v.en; FLUSH = v.flush; DLY_LD = v.ld; DLY = v.dly; IN_VLD = v.vld; IN = v.din;
    #2;
    check(v.tag, v.exp_vld, v.exp_out, v.exp_lvl, v.chk_out);
  endtask

  task automatic run_queue();
    foreach (vq[i]) apply(vq[i]);
    vq.delete();
  endtask

  initial begin
    RST_N = 1'b0; EN = 1'b0; FLUSH = 1'b0; DLY_LD = 1'b0; DLY = '0; IN_VLD = 1'b0; IN = '0;

    // Stream 1..16 through the reset delay of 8.
    for (int k = 0; k < 16; k++)
      add("fill8", 1, 0, 0, 0, 1, k + 1, k >= 8, k - 7, imin(k, 8), k >= 8);
    // Load delay 3 mid-stream.
    add("ld3", 1, 0, 1, 3, 1, 8'h11, 1, 8'h09, 8, 1);
    for (int j = 1; j <= 6; j++)
      add("d3", 1, 0, 0, 0, 1, 17 + j, j >= 4, j + 14, imin(j - 1, 3), j >= 4);
    // Load delay 0 and exercise the bypass.
    add("ld0", 1, 0, 1, 0, 1, 8'h30, 1, 8'h15, 3, 1);
    add("byp_en", 1, 0, 0, 0, 1, 8'hA5, 1, 8'hA5, 0, 1);
    add("byp_stall", 0, 0, 0, 0, 1, 8'hA5, 0, 8'hA5, 0, 1);
    add("byp_novld", 1, 0, 0, 0, 0, 8'h3C, 0, 8'h3C, 0, 1);
    // Delay 4 with a five-cycle stall.
    add("ld4", 0, 0, 1, 4, 0, 8'h00, 0, 8'h00, 0, 1);
    add("st_p10", 1, 0, 0, 0, 1, 8'h10, 0, 0, 0, 0);
    add("st_p11", 1, 0, 0, 0, 1, 8'h11, 0, 0, 1, 0);
    for (int k = 0; k < 5; k++)
      add("stall", 0, 0, 0, 0, 0, 8'hEE, 0, 0, 2, 0);
    add("st_run", 1, 0, 0, 0, 0, 8'h00, 0, 0, 2, 0);
    add("st_run", 1, 0, 0, 0, 0, 8'h00, 0, 0, 2, 0);
    add("st_o10", 1, 0, 0, 0, 0, 8'h00, 1, 8'h10, 2, 1);
    add("st_o11", 1, 0, 0, 0, 0, 8'h00, 1, 8'h11, 1, 1);
    add("st_empty", 1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    // Fill delay 4, then flush with EN and IN_VLD high.
    for (int k = 0; k < 4; k++)
      add("fl_fill", 1, 0, 0, 0, 1, 8'h40 + k, 0, 0, k, 0);
    add("flush", 1, 1, 0, 0, 1, 8'h44, 1, 8'h40, 4, 1);
    for (int m = 0; m < 4; m++)
      add("fl_after", 1, 0, 0, 0, 1, 8'h50 + m, 0, 0, m, 0);
    add("fl_first", 1, 0, 0, 0, 1, 8'h54, 1, 8'h50, 4, 1);
    // Out-of-range load clamps to the full depth.
    add("ld15", 1, 0, 1, 15, 1, 8'h55, 1, 8'h51, 4, 1);
    for (int k = 1; k <= 9; k++)
      add("clamp", 1, 0, 0, 0, 1, 8'h60 + k, k >= 9, 8'h61, imin(k - 1, 8), k >= 9);
    add("ld2", 1, 0, 1, 2, 1, 8'h6A, 1, 8'h62, 8, 1);
    for (int m = 1; m <= 3; m++)
      add("d2", 1, 0, 0, 0, 1, 8'h70 + m, m >= 3, 8'h71, imin(m - 1, 2), m >= 3);

    #12;
    check("reset_state", 1'b0, 8'h00, 4'd0, 1'b1);
    @(negedge CLK);
    RST_N = 1'b1;

    run_queue();

    // Asynchronous reset mid-stream, away from any clock edge.
    @(negedge CLK);
    EN = 1'b1; FLUSH = 1'b0; DLY_LD = 1'b0; IN_VLD = 1'b1; IN = 8'h99;
    #2;
    RST_N = 1'b0;
    #1;
    check("async_rst", 1'b0, 8'h00, 4'd0, 1'b1);
    @(negedge CLK);
    EN = 1'b0; IN_VLD = 1'b0;
    RST_N = 1'b1;

    // Delay is back at ResetDelay, not the 2 loaded before reset.
    for (int k = 0; k < 10; k++)
      add("post_rst", 1, 0, 0, 0, 1, 8'h80 + k, k >= 8, 8'h80 + k - 8, imin(k, 8), k >= 8);
    run_queue();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
